// File: rtl/fetch_decode_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_decode_buffer
//  Description : Circular FIFO between fetch and decode. Each entry is
//                classified (U/J immediate type, illegal encoding) at push.
//  Revision    : 1.0  initial release
// ============================================================================
module fetch_decode_buffer #(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    input  logic [PC_W-1:0]          in_pc,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [6:0]               out_opcode,
    output logic [24:0]              out_instr_data,
    output logic                     out_specifier,
    output logic                     out_uj,
    output logic                     out_illegal,
    output logic [PC_W-1:0]          out_pc,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int                c_aw       = $clog2(DEPTH);
    localparam logic [c_aw:0]     c_full     = (c_aw+1)'(DEPTH);
    localparam logic [c_aw:0]     c_cnt_one  = (c_aw+1)'(1);
    localparam logic [c_aw-1:0]   c_ptr_one  = c_aw'(1);
    localparam logic [6:0]        c_op_jal   = 7'b1101111;
    localparam logic [6:0]        c_op_lui   = 7'b0110111;
    localparam logic [6:0]        c_op_auipc = 7'b0010111;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [24:0]     data;
        logic            specifier;
        logic            uj;
        logic            illegal;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t          r_mem [DEPTH];
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw:0]   r_count;

    entry_t w_new;
    entry_t w_head;
    logic   w_push;
    logic   w_pop;

    assign in_ready  = (r_count < c_full);
    assign out_valid = (r_count != '0);
    assign count     = r_count;
    assign w_push    = in_valid && in_ready;
    assign w_pop     = out_valid && out_ready;

    always_comb begin
        w_new           = '0;
        w_new.opcode    = in_instr[6:0];
        w_new.data      = in_instr[31:7];
        w_new.illegal   = (in_instr[1:0] != 2'b11);
        w_new.pc        = in_pc;
        w_new.specifier = (in_instr[6:0] == c_op_jal);
        w_new.uj        = (in_instr[6:0] == c_op_jal) ||
                          (in_instr[6:0] == c_op_lui) ||
                          (in_instr[6:0] == c_op_auipc);
    end

    // Payload is not reset; the head view below is masked while empty.
    always_ff @(posedge clk) begin
        if (!rst && !flush && w_push) begin
            r_mem[r_wr_ptr] <= w_new;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head         = out_valid ? r_mem[r_rd_ptr] : '0;
    assign out_opcode     = w_head.opcode;
    assign out_instr_data = w_head.data;
    assign out_specifier  = w_head.specifier;
    assign out_uj         = w_head.uj;
    assign out_illegal    = w_head.illegal;
    assign out_pc         = w_head.pc;

endmodule
`default_nettype wire
